// File: rtl/float_mul_round.sv
// Rounding/packing back end of a single-precision multiplier: a two-stage
// pipeline (normalise, then round-to-nearest-even and pack) with valid/ready flow control.
`timescale 1ns/1ps
module float_mul_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);

    logic               w_adv;
    logic [23:0]        w_s1_m;
    logic               w_s1_g;
    logic               w_s1_s;
    logic signed [9:0]  w_s1_exp;

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic signed [9:0]  r_s1_exp;
    logic [23:0]        r_s1_m;
    logic               r_s1_g;
    logic               r_s1_s;
    logic               r_s1_nan;
    logic               r_s1_inf;
    logic               r_s1_zero;

    logic               w_up;
    logic [24:0]        w_m_rnd;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_exp_fin;
    logic [31:0]        w_res;
    logic               w_ovf;
    logic               w_unf;
    logic               w_exc;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Product in [2,4) has its leading one at bit 47 and needs a one-place shift.
    always_comb begin
        if (in_mant[47]) begin
            w_s1_m   = in_mant[47:24];
            w_s1_g   = in_mant[23];
            w_s1_s   = |in_mant[22:0];
            w_s1_exp = $signed(in_exp) + 10'sd1;
        end else begin
            w_s1_m   = in_mant[46:23];
            w_s1_g   = in_mant[22];
            w_s1_s   = |in_mant[21:0];
            w_s1_exp = $signed(in_exp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_m     <= '0;
            r_s1_g     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_zero  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_sign;
                r_s1_exp  <= w_s1_exp;
                r_s1_m    <= w_s1_m;
                r_s1_g    <= w_s1_g;
                r_s1_s    <= w_s1_s;
                r_s1_nan  <= in_nan;
                r_s1_inf  <= in_inf;
                r_s1_zero <= in_zero;
            end
        end
    end

    assign w_up      = r_s1_g & (r_s1_s | r_s1_m[0]);
    assign w_m_rnd   = {1'b0, r_s1_m} + {24'h0, w_up};
    // A rounding carry renormalises by one place; the fraction then becomes zero.
    assign w_frac    = w_m_rnd[24] ? w_m_rnd[23:1] : w_m_rnd[22:0];
    assign w_exp_fin = r_s1_exp + (w_m_rnd[24] ? 10'sd1 : 10'sd0);

    always_comb begin
        w_res = {r_s1_sign, w_exp_fin[7:0], w_frac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_exc = 1'b0;
        if (r_s1_nan || (r_s1_inf && r_s1_zero)) begin
            w_res = 32'h7FC0_0000;
            w_exc = 1'b1;
        end else if (r_s1_inf) begin
            w_res = {r_s1_sign, 8'hFF, 23'h0};
            w_exc = 1'b1;
        end else if (r_s1_zero) begin
            w_res = {r_s1_sign, 31'h0};
        end else if (w_exp_fin >= 10'sd255) begin
            w_res = {r_s1_sign, 8'hFF, 23'h0};
            w_ovf = 1'b1;
        end else if (w_exp_fin <= 10'sd0) begin
            w_res = {r_s1_sign, 31'h0};
            w_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= 32'h0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                result    <= w_res;
                overflow  <= w_ovf;
                underflow <= w_unf;
                exception <= w_exc;
            end
        end
    end

endmodule

// File: tb/tb_float_mul_round.sv
// Self-checking bench for float_mul_round: hand-derived vector table fed through a
// scoreboard queue, plus stall and mid-flight reset sequences.
`timescale 1ns/1ps
module tb_float_mul_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        exception;

    float_mul_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic        nan;
        logic        inf;
        logic        zero;
        logic [34:0] out;  // {result, overflow, underflow, exception}
    } vec_t;

    typedef struct {
        logic [34:0] out;
        int          cyc;
        bit          timed;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    logic [34:0] last_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [9:0] e, input logic [47:0] m,
                                input logic nan, input logic inf, input logic zero,
                                input logic [31:0] res, input logic ovf, input logic unf,
                                input logic exc);
        vec_t v;
        v.sign = s; v.exp = e; v.mant = m;
        v.nan = nan; v.inf = inf; v.zero = zero;
        v.out = {res, ovf, unf, exc};
        return v;
    endfunction

    // Monitor samples 1ns before each rising edge, after all stimulus has settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                last_out = '0;
            end else begin
                check("in_ready", {34'h0, in_ready}, {34'h0, !out_valid || out_ready});
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_output: got %h, expected no output",
                                 {result, overflow, underflow, exception});
                    end else begin
                        e = sb.pop_front();
                        check("result", {result, overflow, underflow, exception}, e.out);
                        if (e.timed) check("latency", 35'(cyc - e.cyc), 35'd2);
                        last_out = e.out;
                    end
                end else if (out_valid) begin
                    if (sb.size() > 0)
                        check("stall_hold", {result, overflow, underflow, exception}, sb[0].out);
                end else begin
                    check("bubble_hold", {result, overflow, underflow, exception}, last_out);
                end
            end
        end
    end

    task automatic send(input vec_t v, input bit timed, input int rdy_pct);
        exp_t e;
        int   tries = 0;
        while (1) begin
            @(negedge clk);
            #1;
            out_ready = ($urandom_range(99) < rdy_pct);
            in_valid  = 1'b1;
            in_sign   = v.sign;
            in_exp    = v.exp;
            in_mant   = v.mant;
            in_nan    = v.nan;
            in_inf    = v.inf;
            in_zero   = v.zero;
            #2;
            if (in_ready) begin
                e.out   = v.out;
                e.cyc   = cyc;
                e.timed = timed;
                sb.push_back(e);
                break;
            end
            tries++;
            if (tries > 100) begin
                n_checks++;
                n_err++;
                $display("FAIL accept_timeout: in_ready=%0b, expected 1 within 100 cycles", in_ready);
                break;
            end
        end
    endtask

    task automatic idle(input int n, input int rdy_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            in_valid  = 1'b0;
            in_mant   = {$urandom, $urandom_range(65535)};
            out_ready = ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            idle(1, 100);
            n++;
        end
        idle(1, 100);
        if (sb.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d items outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl.push_back(mk(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h4010_0000, 0, 0, 0));
        tbl.push_back(mk(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 32'h3F80_0002, 0, 0, 0));
        tbl.push_back(mk(0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0, 32'h4000_0000, 0, 0, 0));
        tbl.push_back(mk(0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'h7F80_0000, 1, 0, 0));
        tbl.push_back(mk(1, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 32'h8000_0000, 0, 1, 0));
        tbl.push_back(mk(0, 10'd127, 48'h4000_0000_0000, 0, 1, 1, 32'h7FC0_0000, 0, 0, 1));
        tbl.push_back(mk(1, 10'd127, 48'h4000_0000_0000, 0, 1, 0, 32'hFF80_0000, 0, 0, 1));
        tbl.push_back(mk(0, 10'd127, 48'h8000_00C0_0000, 0, 0, 0, 32'h4000_0001, 0, 0, 0));
        tbl.push_back(mk(0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 32'h3F80_0000, 0, 0, 0));
        tbl.push_back(mk(1, 10'd127, 48'h4000_013F_FFFF, 0, 0, 0, 32'hBF80_0002, 0, 0, 0));
        tbl.push_back(mk(0, 10'd253, 48'hFFFF_FF80_0000, 0, 0, 0, 32'h7F80_0000, 1, 0, 0));
        tbl.push_back(mk(0, 10'd253, 48'hFFFF_FF00_0000, 0, 0, 0, 32'h7F7F_FFFF, 0, 0, 0));
        tbl.push_back(mk(0, 10'd1,   48'h4000_0000_0000, 0, 0, 0, 32'h0080_0000, 0, 0, 0));
        tbl.push_back(mk(0, 10'd0,   48'h7FFF_FFC0_0000, 0, 0, 0, 32'h0080_0000, 0, 0, 0));
        tbl.push_back(mk(0, 10'h381, 48'h4000_0000_0000, 0, 0, 0, 32'h0000_0000, 0, 1, 0));
        tbl.push_back(mk(0, 10'h17F, 48'h8000_0000_0000, 0, 0, 0, 32'h7F80_0000, 1, 0, 0));
        tbl.push_back(mk(1, 10'd127, 48'h4000_0000_0000, 1, 0, 0, 32'h7FC0_0000, 0, 0, 1));
        tbl.push_back(mk(1, 10'd254, 48'h8000_0000_0000, 0, 0, 1, 32'h8000_0000, 0, 0, 0));
        tbl.push_back(mk(0, 10'd127, 48'h4000_0000_0000, 1, 1, 1, 32'h7FC0_0000, 0, 0, 1));
        tbl.push_back(mk(0, 10'd0,   48'h4000_0000_0000, 0, 1, 0, 32'h7F80_0000, 0, 0, 1));
        tbl.push_back(mk(1, 10'd200, 48'h6000_0000_0000, 0, 0, 0, 32'hE440_0000, 0, 0, 0));
        tbl.push_back(mk(0, 10'h3FF, 48'h8000_0000_0000, 0, 0, 0, 32'h0000_0000, 0, 1, 0));

        rst = 1'b1;
        in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0; out_ready = 1'b1;
        #2;
        check("reset_state", {out_valid, result, overflow, underflow, exception, in_ready}, 35'h1);
        idle(2, 100);
        rst = 1'b0;
        idle(2, 100);

        // Back-to-back table at full throughput; latency is checked per item.
        for (int i = 0; i < tbl.size(); i++) send(tbl[i], 1'b1, 100);
        drain();

        // Stall: two items captured while downstream is blocked, held for three cycles.
        send(tbl[0], 1'b0, 0);
        send(tbl[1], 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1, 0);
            #2;
            check("stall_in_ready", {34'h0, in_ready}, 35'h0);
            check("stall_result", {result, overflow, underflow, exception}, tbl[0].out);
        end
        drain();

        // Reset with two items in flight; neither may emerge afterwards.
        send(tbl[2], 1'b0, 100);
        send(tbl[3], 1'b0, 100);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset_out", {out_valid, result, overflow, underflow, exception, in_ready}, 35'h1);
        sb.delete();
        idle(2, 100);
        rst = 1'b0;
        idle(4, 100);
        send(tbl[20], 1'b1, 100);
        drain();

        // Random backpressure and bubbles across the whole table.
        for (int i = 0; i < 150; i++) begin
            send(tbl[$urandom_range(tbl.size() - 1)], 1'b0, 60);
            if ($urandom_range(3) == 0) idle($urandom_range(1, 3), 50);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
